dp_ram_resp: RTL and testbench



---
 rtl/dp_ram_pkg.sv | 20 ++
 rtl/dp_ram_rd_pipe.sv | 50 +++++
 rtl/dp_ram_resp.sv | 105 ++++++++++
 tb/tb_dp_ram_resp.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared widths, typedefs and the read-pipeline payload for the dual-port RAM responder.
package dp_ram_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic  valid;
    logic  uninit;
    logic  collision;
    data_t data;
  } rd_pipe_t;

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// RD_LAT-deep read-result pipeline; the data field of each stage holds while no read passes through.
module dp_ram_rd_pipe
  import dp_ram_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rd_pipe_t pipe_in,
  output rd_pipe_t pipe_out
);

  rd_pipe_t src_c   [RD_LAT];
  rd_pipe_t stage_d [RD_LAT];
  rd_pipe_t stage_q [RD_LAT];

  // Empty slots carry zero strobes but keep the last delivered data.
  always_comb begin
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      src_c[i]   = '0;
      stage_d[i] = '0;
    end
    src_c[0] = pipe_in;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      src_c[i] = stage_q[i-1];
    end
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      if (src_c[i].valid) begin
        stage_d[i] = src_c[i];
      end else begin
        stage_d[i].data = stage_q[i].data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign pipe_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/dp_ram_resp.sv
// 16x8 dual-port RAM responder: write-first forwarding, written-since-reset tracking, saturating counters.
module dp_ram_resp #(
  parameter int unsigned DATA_W = dp_ram_pkg::DATA_W,
  parameter int unsigned ADDR_W = dp_ram_pkg::ADDR_W,
  parameter int unsigned DEPTH  = dp_ram_pkg::DEPTH,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = dp_ram_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              rd_uninit,
  output logic              collision,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  import dp_ram_pkg::*;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  wbit_d, wbit_q;
  logic [CNT_W-1:0]  wr_cnt_d, wr_cnt_q;
  logic [CNT_W-1:0]  rd_cnt_d, rd_cnt_q;

  logic     collision_c;
  logic     wbit_rd_c;
  rd_pipe_t pipe_in_c;
  rd_pipe_t pipe_out;

  // Storage and written-bits update on an accepted write.
  always_comb begin
    mem_d  = mem_q;
    wbit_d = wbit_q;
    if (write) begin
      mem_d[wr_addr]  = data_in;
      wbit_d[wr_addr] = 1'b1;
    end
  end

  // Saturating access counters.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (write && !(&wr_cnt_q)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
    if (read  && !(&rd_cnt_q)) rd_cnt_d = rd_cnt_q + CNT_W'(1);
  end

  // Stage-1 capture: same-address write wins, unwritten locations read as zero.
  always_comb begin
    collision_c = write && (wr_addr == rd_addr);
    wbit_rd_c   = wbit_q[rd_addr];
    pipe_in_c   = '0;
    if (read) begin
      pipe_in_c.valid     = 1'b1;
      pipe_in_c.collision = collision_c;
      pipe_in_c.uninit    = !wbit_rd_c && !collision_c;
      if (collision_c) begin
        pipe_in_c.data = data_in;
      end else if (wbit_rd_c) begin
        pipe_in_c.data = mem_q[rd_addr];
      end
    end
  end

  // The array itself is deliberately not reset; wbit_q masks stale contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbit_q   <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wbit_q   <= wbit_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  dp_ram_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .pipe_in  (pipe_in_c),
    .pipe_out (pipe_out)
  );

  assign data_out  = pipe_out.data;
  assign rd_valid  = pipe_out.valid;
  assign rd_uninit = pipe_out.uninit;
  assign collision = pipe_out.collision;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_dp_ram_resp.sv
// Directed, table-driven bench for dp_ram_resp at RD_LAT=1, RD_LAT=2 and a narrow-counter build.
module tb_dp_ram_resp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       write, read;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] data_in;

  logic [7:0]  d1, d2, d3;
  logic        v1, v2, v3, u1, u2, u3, c1, c2, c3;
  logic [15:0] wc1, rc1, wc2, rc2;
  logic [3:0]  wc3, rc3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dp_ram_resp #(.RD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .write(write), .wr_addr(wr_addr), .data_in(data_in),
    .read(read), .rd_addr(rd_addr), .data_out(d1), .rd_valid(v1), .rd_uninit(u1),
    .collision(c1), .wr_count(wc1), .rd_count(rc1));

  dp_ram_resp #(.RD_LAT(2), .CNT_W(16)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .write(write), .wr_addr(wr_addr), .data_in(data_in),
    .read(read), .rd_addr(rd_addr), .data_out(d2), .rd_valid(v2), .rd_uninit(u2),
    .collision(c2), .wr_count(wc2), .rd_count(rc2));

  dp_ram_resp #(.RD_LAT(1), .CNT_W(4)) u_cnt4 (
    .clk(clk), .rst_n(rst_n), .write(write), .wr_addr(wr_addr), .data_in(data_in),
    .read(read), .rd_addr(rd_addr), .data_out(d3), .rd_valid(v3), .rd_uninit(u3),
    .collision(c3), .wr_count(wc3), .rd_count(rc3));

  typedef struct {
    logic       wr;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       rd;
    logic [3:0] ra;
    logic       ev;
    logic [7:0] ed;
    logic       eu;
    logic       ec;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare one DUT's read outputs against an expected tuple.
  task automatic chk_rd(input string nm, input int which, input logic ev, input logic [7:0] ed,
                        input logic eu, input logic ec);
    logic [7:0] d;
    logic v, u, c;
    case (which)
      1:       begin d = d1; v = v1; u = u1; c = c1; end
      2:       begin d = d2; v = v2; u = u2; c = c2; end
      default: begin d = d3; v = v3; u = u3; c = c3; end
    endcase
    chk({nm, ".valid"},  32'(v), 32'(ev));
    chk({nm, ".data"},   32'(d), 32'(ed));
    chk({nm, ".uninit"}, 32'(u), 32'(eu));
    chk({nm, ".coll"},   32'(c), 32'(ec));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    write = 1'b0; read = 1'b0; wr_addr = '0; rd_addr = '0; data_in = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(logic wr, logic [3:0] wa, logic [7:0] wd, logic rd, logic [3:0] ra,
                              logic ev, logic [7:0] ed, logic eu, logic ec);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
    v.ev = ev; v.ed = ed; v.eu = eu; v.ec = ec;
    return v;
  endfunction

  initial begin
    logic       pv, pu, pc;
    logic [7:0] pd, last1, last2;

    tbl[0]  = mk(0, 4'h0, 8'h00, 1, 4'h5, 1, 8'h00, 1, 0);
    tbl[1]  = mk(1, 4'h3, 8'hA5, 0, 4'h0, 0, 8'h00, 0, 0);
    tbl[2]  = mk(0, 4'h0, 8'h00, 1, 4'h3, 1, 8'hA5, 0, 0);
    tbl[3]  = mk(1, 4'h7, 8'h11, 0, 4'h0, 0, 8'h00, 0, 0);
    tbl[4]  = mk(1, 4'h7, 8'h3C, 1, 4'h7, 1, 8'h3C, 0, 1);
    tbl[5]  = mk(0, 4'h0, 8'h00, 1, 4'h7, 1, 8'h3C, 0, 0);
    tbl[6]  = mk(0, 4'h0, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0);
    tbl[7]  = mk(1, 4'h2, 8'h55, 1, 4'h3, 1, 8'hA5, 0, 0);
    tbl[8]  = mk(0, 4'h0, 8'h00, 1, 4'h2, 1, 8'h55, 0, 0);
    tbl[9]  = mk(1, 4'h4, 8'h99, 1, 4'h4, 1, 8'h99, 0, 1);
    tbl[10] = mk(0, 4'h0, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0);

    // Reset state.
    do_reset();
    for (int w = 1; w <= 3; w++) chk_rd($sformatf("reset.dut%0d", w), w, 0, 8'h00, 0, 0);
    chk("reset.wc1", 32'(wc1), 32'd0);
    chk("reset.rc2", 32'(rc2), 32'd0);
    chk("reset.wc3", 32'(wc3), 32'd0);

    // Directed vectors; the RD_LAT=2 instance is checked one row behind.
    pv = 1'b0; pd = 8'h00; pu = 1'b0; pc = 1'b0;
    last1 = 8'h00; last2 = 8'h00;
    for (int k = 0; k < 11; k++) begin
      write = tbl[k].wr; wr_addr = tbl[k].wa; data_in = tbl[k].wd;
      read  = tbl[k].rd; rd_addr = tbl[k].ra;
      tick();
      if (tbl[k].ev) last1 = tbl[k].ed;
      chk_rd($sformatf("vec%0d.lat1", k), 1, tbl[k].ev, last1, tbl[k].eu, tbl[k].ec);
      if (pv) last2 = pd;
      chk_rd($sformatf("vec%0d.lat2", k), 2, pv, last2, pu, pc);
      if (k == 0) chk("vec0.rd_count", 32'(rc1), 32'd1);
      pv = tbl[k].ev; pd = tbl[k].ed; pu = tbl[k].eu; pc = tbl[k].ec;
    end
    idle_in();
    chk("vec.wr_count1", 32'(wc1), 32'd5);
    chk("vec.rd_count1", 32'(rc1), 32'd7);
    chk("vec.wr_count2", 32'(wc2), 32'd5);
    chk("vec.rd_count2", 32'(rc2), 32'd7);
    chk("vec.rd_count3", 32'(rc3), 32'd7);

    // Fill all 16 words, then stream 16 back-to-back reads.
    for (int a = 0; a < 16; a++) begin
      write = 1'b1; wr_addr = 4'(a); data_in = 8'(a) ^ 8'hF0; read = 1'b0;
      tick();
    end
    write = 1'b0;
    for (int a = 0; a < 16; a++) begin
      read = 1'b1; rd_addr = 4'(a);
      tick();
      chk_rd($sformatf("burst%0d.lat1", a), 1, 1, 8'hF0 + 8'(a), 0, 0);
      if (a == 0) chk_rd("burst0.lat2", 2, 0, last2, 0, 0);
      else        chk_rd($sformatf("burst%0d.lat2", a), 2, 1, 8'hF0 + 8'(a - 1), 0, 0);
    end
    idle_in();
    tick();
    chk_rd("burst_end.lat1", 1, 0, 8'hFF, 0, 0);
    chk_rd("burst_end.lat2", 2, 1, 8'hFF, 0, 0);
    tick();
    chk_rd("burst_idle.lat2", 2, 0, 8'hFF, 0, 0);

    // Reset lands while an RD_LAT=2 read is in flight.
    write = 1'b1; wr_addr = 4'h3; data_in = 8'h77;
    tick();
    write = 1'b0; read = 1'b1; rd_addr = 4'h3;
    tick();
    chk_rd("flush.lat1", 1, 1, 8'h77, 0, 0);
    idle_in();
    rst_n = 1'b0;
    #1;
    chk("flush.wc1_async", 32'(wc1), 32'd0);
    chk("flush.rc2_async", 32'(rc2), 32'd0);
    chk_rd("flush.lat2_async", 2, 0, 8'h00, 0, 0);
    tick();
    chk_rd("flush.lat2_e1", 2, 0, 8'h00, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_rd("flush.lat2_e3", 2, 0, 8'h00, 0, 0);
    read = 1'b1; rd_addr = 4'h3;
    tick();
    idle_in();
    chk_rd("post_rst.lat1", 1, 1, 8'h00, 1, 0);
    chk("post_rst.wc1", 32'(wc1), 32'd0);
    tick();
    chk_rd("post_rst.lat2", 2, 1, 8'h00, 1, 0);
    chk("post_rst.wc2", 32'(wc2), 32'd0);

    // Narrow counter saturation.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      write = 1'b1; wr_addr = 4'(k); data_in = 8'(k);
      tick();
      chk($sformatf("sat%0d.wc3", k), 32'(wc3), (k + 1 > 15) ? 32'd15 : 32'(k + 1));
      chk($sformatf("sat%0d.rc3", k), 32'(rc3), 32'd0);
    end
    idle_in();
    tick();
    chk("sat.hold.wc3", 32'(wc3), 32'd15);
    chk("sat.wc1", 32'(wc1), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
